// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if -- bundle of the instruction-memory arbiter's bus signals.
//
// Purpose: groups the fetch request/response handshakes, the loader write
// handshake and the single-port memory interface so the arbiter and its
// environment connect through one port.
//
// Signals:
//   f_req_valid/f_req_ready, f_addr              fetch request (byte address)
//   f_rsp_valid/f_rsp_ready, f_rsp_data, f_rsp_err  fetch response
//   l_req_valid/l_req_ready, l_addr, l_wdata     loader write request
//   l_done, l_err                                loader write-complete pulse
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata  synchronous memory port
//
// Modports: slave  = arbiter side, master = requesters + memory side.
interface imem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              f_req_valid;
    logic              f_req_ready;
    logic [31:0]       f_addr;
    logic              f_rsp_valid;
    logic              f_rsp_ready;
    logic [31:0]       f_rsp_data;
    logic              f_rsp_err;
    logic              l_req_valid;
    logic              l_req_ready;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_done;
    logic              l_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_req_valid, f_addr, f_rsp_ready,
        input  l_req_valid, l_addr, l_wdata,
        input  mem_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
        output l_req_ready, l_done, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req_valid, f_addr, f_rsp_ready,
        output l_req_valid, l_addr, l_wdata,
        output mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
        input  l_req_ready, l_done, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter -- shares one single-port synchronous instruction memory
// between an instruction fetch port (reads) and a loader port (writes).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    imem_arbiter_if.slave: fetch/loader handshakes and memory port
//
// Parameter: ADDR_W -- word-index width (2**ADDR_W 32-bit words).
//
// Optional feature: define IMEM_ARB_RR_EN for round-robin arbitration in
// IDLE; otherwise the loader always has priority over fetch.
//
// A fetch occupies IDLE -> RD -> HOLD; the loader may still write during RD
// and HOLD. The read was already launched in the accept cycle, so a write in
// RD cannot disturb the returned word.
module imem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   fetch_win_s;
    logic   f_acc_s;
    logic   l_acc_s;
    logic   f_bad_r;

    // Misaligned or beyond the memory range.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    endfunction

`ifdef IMEM_ARB_RR_EN
    logic prefer_fetch_r;

    // Round-robin: fetch wins a tie only when it is its turn.
    always_comb begin
        fetch_win_s = bus.f_req_valid && (!bus.l_req_valid || prefer_fetch_r);
    end

    // Turn pointer flips to the requester that lost the last IDLE grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prefer_fetch_r <= 1'b0;
        end else if (state_r == IDLE && f_acc_s) begin
            prefer_fetch_r <= 1'b0;
        end else if (state_r == IDLE && l_acc_s) begin
            prefer_fetch_r <= 1'b1;
        end
    end
`else
    // Fixed priority: loader beats fetch.
    always_comb begin
        fetch_win_s = bus.f_req_valid && !bus.l_req_valid;
    end
`endif

    // Next state, handshake readies and the memory command for this cycle.
    always_comb begin
        state_s         = state_r;
        f_acc_s         = 1'b0;
        l_acc_s         = 1'b0;
        bus.f_req_ready = 1'b0;
        bus.l_req_ready = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = {ADDR_W{1'b0}};
        bus.mem_wdata   = 32'd0;
        if (!rst_n) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fetch_win_s) begin
                        bus.f_req_ready = 1'b1;
                        f_acc_s         = 1'b1;
                        state_s         = RD;
                    end else begin
                        bus.l_req_ready = 1'b1;
                        l_acc_s         = bus.l_req_valid;
                    end
                end
                RD: begin
                    bus.l_req_ready = 1'b1;
                    l_acc_s         = bus.l_req_valid;
                    state_s         = HOLD;
                end
                HOLD: begin
                    bus.l_req_ready = 1'b1;
                    l_acc_s         = bus.l_req_valid;
                    if (bus.f_rsp_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase

            // Bad addresses are accepted but never reach the memory.
            if (f_acc_s) begin
                bus.mem_addr = bus.f_addr[ADDR_W+1:2];
                bus.mem_en   = !addr_bad(bus.f_addr);
            end else if (l_acc_s) begin
                bus.mem_addr  = bus.l_addr[ADDR_W+1:2];
                bus.mem_wdata = bus.l_wdata;
                bus.mem_en    = !addr_bad(bus.l_addr);
                bus.mem_we    = !addr_bad(bus.l_addr);
            end else begin
                bus.mem_en = 1'b0;
            end
        end
    end

    // State register, response capture/hold and loader completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            f_bad_r         <= 1'b0;
            bus.f_rsp_valid <= 1'b0;
            bus.f_rsp_err   <= 1'b0;
            bus.f_rsp_data  <= 32'd0;
            bus.l_done      <= 1'b0;
            bus.l_err       <= 1'b0;
        end else begin
            state_r    <= state_s;
            bus.l_done <= l_acc_s;
            bus.l_err  <= l_acc_s && addr_bad(bus.l_addr);
            if (f_acc_s) begin
                f_bad_r <= addr_bad(bus.f_addr);
            end
            case (state_r)
                RD: begin
                    bus.f_rsp_valid <= 1'b1;
                    bus.f_rsp_err   <= f_bad_r;
                    bus.f_rsp_data  <= f_bad_r ? 32'd0 : bus.mem_rdata;
                end
                HOLD: begin
                    if (bus.f_rsp_ready) begin
                        bus.f_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    bus.f_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter -- randomized + directed bench for imem_arbiter with a
// transaction-level reference model (pending fetch with age, word array,
// turn flag for round-robin builds).
module tb_imem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    imem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Environment memory: synchronous single-port RAM.
    logic [31:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= env_mem[bus.mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    bit          pend;
    int          age;
    logic [31:0] pend_data;
    bit          pend_err;
    bit          done_exp;
    bit          done_err_exp;
    bit          prefer_fetch;
    bit          after_reset;

    function automatic bit bad(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic step(input bit rst_i, input bit fv, input logic [31:0] fa, input bit fr,
                        input bit lv, input logic [31:0] la, input logic [31:0] lw);
        bit fwin, facc, lacc, vis, was_pend, exp_en, exp_we;
        logic [31:0] exp_idx;
        @(negedge clk);
        rst_n           = rst_i;
        bus.f_req_valid = fv;
        bus.f_addr      = fa;
        bus.f_rsp_ready = fr;
        bus.l_req_valid = lv;
        bus.l_addr      = la;
        bus.l_wdata     = lw;
        #1;
        facc = 1'b0;
        lacc = 1'b0;
        vis  = 1'b0;
        if (!rst_i) begin
            check_eq("rst_f_req_ready", 32'(bus.f_req_ready), 32'd0);
            check_eq("rst_l_req_ready", 32'(bus.l_req_ready), 32'd0);
            check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
            check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        end else begin
            fwin = fv && (!lv || (RR && prefer_fetch));
            check_eq("f_req_ready", 32'(bus.f_req_ready), 32'(!pend && fwin));
            check_eq("l_req_ready", 32'(bus.l_req_ready), 32'(pend || !fwin));
            facc = !pend && fwin && fv;
            lacc = (pend || !fwin) && lv;
            exp_en = (facc && !bad(fa)) || (lacc && !bad(la));
            exp_we = lacc && !bad(la);
            check_eq("mem_en", 32'(bus.mem_en), 32'(exp_en));
            check_eq("mem_we", 32'(bus.mem_we), 32'(exp_we));
            if (exp_en) begin
                exp_idx = (facc ? fa : la) / 32'd4;
                check_eq("mem_addr", 32'(bus.mem_addr), exp_idx);
            end
            if (exp_we) check_eq("mem_wdata", bus.mem_wdata, lw);
            vis = pend && age >= 2;
            check_eq("f_rsp_valid", 32'(bus.f_rsp_valid), 32'(vis));
            if (vis) begin
                check_eq("f_rsp_data", bus.f_rsp_data, pend_data);
                check_eq("f_rsp_err", 32'(bus.f_rsp_err), 32'(pend_err));
            end
            if (after_reset) begin
                check_eq("reset_rsp_data", bus.f_rsp_data, 32'd0);
                check_eq("reset_rsp_err", 32'(bus.f_rsp_err), 32'd0);
            end
            check_eq("l_done", 32'(bus.l_done), 32'(done_exp));
            if (done_exp) check_eq("l_err", 32'(bus.l_err), 32'(done_err_exp));
        end
        // Advance the model across the coming rising edge.
        if (!rst_i) begin
            pend         = 1'b0;
            done_exp     = 1'b0;
            done_err_exp = 1'b0;
            prefer_fetch = 1'b0;
            after_reset  = 1'b1;
        end else begin
            after_reset  = 1'b0;
            was_pend     = pend;
            done_exp     = lacc;
            done_err_exp = lacc && bad(la);
            if (lacc && !bad(la)) ref_mem[la / 32'd4] = lw;
            if (pend) begin
                if (vis && fr) pend = 1'b0;
                else age++;
            end
            if (facc) begin
                pend      = 1'b1;
                age       = 1;
                pend_err  = bad(fa);
                pend_data = bad(fa) ? 32'd0 : ref_mem[fa / 32'd4];
            end
            if (!was_pend) begin
                if (facc) prefer_fetch = 1'b0;
                else if (lacc) prefer_fetch = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        a = ($urandom % 16) * 4;
        r = $urandom % 10;
        if (r == 0) a = a | (1 + $urandom % 3);
        else if (r == 1) a = a | (32'h0000_1000 << ($urandom % 20));
        return a;
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.f_req_valid = 1'b0;
        bus.f_addr      = 32'd0;
        bus.f_rsp_ready = 1'b0;
        bus.l_req_valid = 1'b0;
        bus.l_addr      = 32'd0;
        bus.l_wdata     = 32'd0;
        bus.mem_rdata   = 32'd0;
        pend = 1'b0; age = 0; pend_data = 32'd0; pend_err = 1'b0;
        done_exp = 1'b0; done_err_exp = 1'b0; prefer_fetch = 1'b0; after_reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        env_mem[4] = 32'hAAAA_0000;
        ref_mem[4] = 32'hAAAA_0000;

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(1);

        // Write then fetch the same word.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'h0050_0093);
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(4);

        // Held response with back-pressure and a fetch waiting.
        step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(2);

        // Bad addresses.
        step(1'b1, 1'b1, 32'h6, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(3);
        step(1'b1, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(3);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h2, 32'hDEAD_BEEF);
        idle(2);

        // Contention: both requesters valid.
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h20 + 32'(k * 4), $urandom);
        idle(3);

        // Write to the in-flight read address during RD.
        step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'h5555_0000);
        idle(2);
        step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(3);

        // Reset during RD and during HOLD.
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(4);
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(4);
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(3);

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 2000; k++) begin
            step(($urandom % 200) != 0, ($urandom % 2) == 1, rand_addr(), ($urandom % 4) != 0,
                 ($urandom % 3) == 0, rand_addr(), $urandom);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
